// File: rtl/test43_pkg.sv
// Shared constants and 1-bit full-adder equations for the test43 adder slice.
package test43_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

endpackage

// File: rtl/test43_full_adder_if.sv
// Operand/result bus of the registered adder; ovf exists only when TEST43_OVF_EN is defined.
interface test43_full_adder_if #(
  parameter int unsigned WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;
`ifdef TEST43_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, b, c, input sum, carry, out_valid, ovf);
  modport slave  (input in_valid, a, b, c, output sum, carry, out_valid, ovf);
`else
  modport master (output in_valid, a, b, c, input sum, carry, out_valid);
  modport slave  (input in_valid, a, b, c, output sum, carry, out_valid);
`endif

endinterface

// File: rtl/test43_fa_cell.sv
// Combinational 1-bit full adder cell, the leaf of the ripple chain.
module test43_fa_cell
  import test43_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = fa_sum(a, b, cin);
  assign cout = fa_carry(a, b, cin);

endmodule

// File: rtl/test43_full_adder.sv
// Registered ripple-carry adder: {carry,sum} = a + b + c, one cycle latency.
// Optional feature macro: TEST43_OVF_EN adds a registered signed-overflow flag (ovf).
module test43_full_adder
  import test43_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input logic               clk,
  input logic               rst_n,
  test43_full_adder_if.slave bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("test43_full_adder: WIDTH out of range 1..64");
  end

  logic [WIDTH:0]   k_c;
  logic [WIDTH-1:0] sum_c;

  assign k_c[0] = bus.c;

  // Ripple chain: cell i consumes k_c[i] and produces k_c[i+1].
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    test43_fa_cell u_cell (
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .cin  (k_c[i]),
      .s    (sum_c[i]),
      .cout (k_c[i+1])
    );
  end

  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             valid_q;

  // Result registers load only on accepted input, so idle-cycle inputs never reach state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        sum_q   <= sum_c;
        carry_q <= k_c[WIDTH];
      end
    end
  end

  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.out_valid = valid_q;

`ifdef TEST43_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.in_valid) begin
      ovf_q <= k_c[WIDTH] ^ k_c[WIDTH-1];
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_test43_full_adder.sv
// Scoreboard bench for test43_full_adder at WIDTH=1 and WIDTH=8.
module tb_test43_full_adder;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst8_n;

  int n_pass  = 0;
  int n_total = 0;

  exp_t q1[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  test43_full_adder_if #(.WIDTH(1)) bus1 ();
  test43_full_adder_if #(.WIDTH(8)) bus8 ();

  test43_full_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst1_n), .bus(bus1));
  test43_full_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8));

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive1(input logic a, input logic b, input logic c,
                        input logic s, input logic co, input logic ov);
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.a = a;
    bus1.b = b;
    bus1.c = c;
    q1.push_back('{sum: {7'd0, s}, carry: co, ovf: ov});
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] s, input logic co, input logic ov);
    @(negedge clk);
    bus8.in_valid = 1'b1;
    bus8.a = a;
    bus8.b = b;
    bus8.c = c;
    q8.push_back('{sum: s, carry: co, ovf: ov});
  endtask

  // Monitors: pop and compare whenever a DUT presents a result.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus1.out_valid === 1'b1) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_valid", 9'd1, 9'd0);
      end else begin
        e = q1.pop_front();
        chk("w1_sum", 9'(bus1.sum), 9'(e.sum));
        chk("w1_carry", 9'(bus1.carry), 9'(e.carry));
`ifdef TEST43_OVF_EN
        chk("w1_ovf", 9'(bus1.ovf), 9'(e.ovf));
`endif
      end
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus8.out_valid === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_valid", 9'd1, 9'd0);
      end else begin
        e = q8.pop_front();
        chk("w8_sum", 9'(bus8.sum), 9'(e.sum));
        chk("w8_carry", 9'(bus8.carry), 9'(e.carry));
`ifdef TEST43_OVF_EN
        chk("w8_ovf", 9'(bus8.ovf), 9'(e.ovf));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst1_n = 1'b0;
    rst8_n = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.a = 1'b1;
    bus1.b = 1'b1;
    bus1.c = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.a = 8'd0;
    bus8.b = 8'd0;
    bus8.c = 1'b0;

    // Reset held two edges with valid all-ones inputs: outputs stay zero.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_sum", 9'(bus1.sum), 9'd0);
      chk("rst_carry", 9'(bus1.carry), 9'd0);
      chk("rst_valid", 9'(bus1.out_valid), 9'd0);
      chk("rst8_valid", 9'(bus8.out_valid), 9'd0);
    end
    rst1_n = 1'b1;
    rst8_n = 1'b1;
    bus1.in_valid = 1'b0;

    // WIDTH=1 exhaustive truth table.
    drive1(0, 0, 0, 0, 0, 0);
    drive1(0, 0, 1, 1, 0, 1);
    drive1(0, 1, 0, 1, 0, 0);
    drive1(0, 1, 1, 0, 1, 0);
    drive1(1, 0, 0, 1, 0, 0);
    drive1(1, 0, 1, 0, 1, 0);
    drive1(1, 1, 0, 0, 1, 1);
    drive1(1, 1, 1, 1, 1, 0);

    // Hold: result of 1+1+0 persists while in_valid is low.
    drive1(1, 1, 0, 0, 1, 1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus1.a = 1'b0;
    bus1.b = 1'b1;
    bus1.c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_sum", 9'(bus1.sum), 9'd0);
      chk("hold_carry", 9'(bus1.carry), 9'd1);
      chk("hold_valid", 9'(bus1.out_valid), 9'd0);
    end

    // WIDTH=8 boundary vectors.
    drive8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    drive8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    drive8(8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0, 1'b0);
    drive8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    drive8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Mid-stream reset: in-flight result shown, then cleared by reset.
    drive8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
    @(negedge clk);
    rst8_n = 1'b0;
    bus8.in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_sum", 9'(bus8.sum), 9'd0);
    chk("midrst_carry", 9'(bus8.carry), 9'd0);
    chk("midrst_valid", 9'(bus8.out_valid), 9'd0);
    rst8_n = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.a = 8'h55;
    bus8.b = 8'hAA;
    bus8.c = 1'b1;
    q8.push_back('{sum: 8'h00, carry: 1'b1, ovf: 1'b0});
    @(negedge clk);
    bus8.in_valid = 1'b0;

    repeat (3) @(negedge clk);
    chk("q1_drained", 9'(q1.size()), 9'd0);
    chk("q8_drained", 9'(q8.size()), 9'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
